// File: rtl/prbs_pkg.sv
// Shared PRBS31 definitions (x^31 + x^28 + 1) and the BERT controller state encoding.
package prbs_pkg;

  localparam int unsigned PRBS31_TAP_A = 30;
  localparam int unsigned PRBS31_TAP_B = 27;
  localparam int unsigned PRBS31_LEN   = 31;

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    SYNC,
    COUNT,
    DONE
  } bert_state_e;

endpackage

// File: rtl/prbs31_hist.sv
// PRBS31 history register: shifts either the received bit (self-synchronising)
// or its own feedback (free-running) and presents the expected next bit.
module prbs31_hist
  import prbs_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic shift_en,
  input  logic load_sel,
  input  logic rx_bit,
  output logic exp_bit
);

  logic [PRBS31_LEN-1:0] hist_q, hist_d;

  always_comb begin
    exp_bit = hist_q[PRBS31_TAP_A] ^ hist_q[PRBS31_TAP_B];
    hist_d  = hist_q;
    if (shift_en) begin
      hist_d = {hist_q[PRBS31_LEN-2:0], (load_sel ? rx_bit : exp_bit)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '1;
    end else begin
      hist_q <= hist_d;
    end
  end

endmodule

// File: rtl/prbs31_bert_ctrl.sv
// PRBS31 bit-error-rate test controller: seed capture, sync qualification,
// windowed error counting with loss-of-sync detection.
module prbs31_bert_ctrl
  import prbs_pkg::*;
#(
  parameter int unsigned SYNC_LEN = 32,
  parameter int unsigned LOS_BLK  = 64,
  parameter int unsigned LOS_THR  = 8,
  parameter int unsigned WIN_W    = 24,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             rx_bit,
  input  logic             rx_valid,
  input  logic [WIN_W-1:0] win_len,
  output logic             busy,
  output logic             locked,
  output logic             done,
  output logic             sync_lost,
  output logic [CNT_W-1:0] err_cnt,
  output logic [WIN_W-1:0] bit_cnt
);

  localparam int unsigned BLK_W = $clog2(LOS_BLK);
  localparam int unsigned BE_W  = $clog2(LOS_THR + 1);
  localparam int unsigned MC_W  = $clog2(SYNC_LEN + 1);
  localparam int unsigned SC_W  = $clog2(PRBS31_LEN + 1);

  bert_state_e      state_q, state_d;
  logic [SC_W-1:0]  seed_cnt_q, seed_cnt_d;
  logic [MC_W-1:0]  match_cnt_q, match_cnt_d;
  logic [BLK_W-1:0] blk_pos_q, blk_pos_d;
  logic [BE_W-1:0]  blk_err_q, blk_err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [WIN_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic             sync_lost_q, sync_lost_d;

  logic             exp_bit, shift_en, load_sel;
  logic             err_bit, seed_last, sync_last, los_hit, win_hit;
  logic [BE_W-1:0]  blk_err_inc;
  logic [WIN_W-1:0] bit_cnt_inc;

  prbs31_hist u_hist (
    .clk      (clk),
    .rst      (rst_n),
    .shift_en (shift_en),
    .load_sel (load_sel),
    .rx_bit   (rx_bit),
    .exp_bit  (exp_bit)
  );

  always_comb begin
    err_bit     = rx_bit ^ exp_bit;
    blk_err_inc = blk_err_q + BE_W'(err_bit);
    bit_cnt_inc = (bit_cnt_q == '1) ? bit_cnt_q : bit_cnt_q + WIN_W'(1);
    seed_last   = (seed_cnt_q == SC_W'(PRBS31_LEN - 1));
    sync_last   = (match_cnt_q == MC_W'(SYNC_LEN - 1));
    los_hit     = (blk_err_inc == BE_W'(LOS_THR));
    win_hit     = (win_q != '0) && (bit_cnt_inc == win_q);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Window end takes precedence over loss of sync on the same bit.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: if (start) state_d = SEED;
        SEED:       if (rx_valid && seed_last) state_d = SYNC;
        SYNC: begin
          if (rx_valid) begin
            if (err_bit)        state_d = SEED;
            else if (sync_last) state_d = COUNT;
          end
        end
        COUNT: begin
          if (rx_valid) begin
            if (win_hit)      state_d = DONE;
            else if (los_hit) state_d = SEED;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Per-state counters reset whenever their state is not active, which also
  // covers the explicit clears on start, sync mismatch and loss of sync.
  always_comb begin
    seed_cnt_d  = (state_q == SEED)  ? seed_cnt_q  : '0;
    match_cnt_d = (state_q == SYNC)  ? match_cnt_q : '0;
    blk_pos_d   = (state_q == COUNT) ? blk_pos_q   : '0;
    blk_err_d   = (state_q == COUNT) ? blk_err_q   : '0;
    err_cnt_d   = err_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    win_d       = win_q;
    sync_lost_d = sync_lost_q;
    shift_en    = 1'b0;
    load_sel    = 1'b1;
    if (!abort) begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            err_cnt_d   = '0;
            bit_cnt_d   = '0;
            sync_lost_d = 1'b0;
            win_d       = win_len;
          end
        end
        SEED: begin
          if (rx_valid) begin
            shift_en   = 1'b1;
            seed_cnt_d = seed_cnt_q + SC_W'(1);
          end
        end
        SYNC: begin
          if (rx_valid) begin
            shift_en    = 1'b1;
            match_cnt_d = err_bit ? '0 : match_cnt_q + MC_W'(1);
          end
        end
        COUNT: begin
          if (rx_valid) begin
            shift_en  = 1'b1;
            load_sel  = 1'b0;
            bit_cnt_d = bit_cnt_inc;
            if (err_bit && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
            if (los_hit) sync_lost_d = 1'b1;
            blk_pos_d = blk_pos_q + BLK_W'(1);
            blk_err_d = (blk_pos_q == '1) ? '0 : blk_err_inc;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      seed_cnt_q  <= '0;
      match_cnt_q <= '0;
      blk_pos_q   <= '0;
      blk_err_q   <= '0;
      err_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      win_q       <= '0;
      sync_lost_q <= 1'b0;
    end else begin
      seed_cnt_q  <= seed_cnt_d;
      match_cnt_q <= match_cnt_d;
      blk_pos_q   <= blk_pos_d;
      blk_err_q   <= blk_err_d;
      err_cnt_q   <= err_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      win_q       <= win_d;
      sync_lost_q <= sync_lost_d;
    end
  end

  always_comb begin
    busy      = (state_q == SEED) || (state_q == SYNC) || (state_q == COUNT);
    locked    = (state_q == COUNT);
    done      = (state_q == DONE);
    sync_lost = sync_lost_q;
    err_cnt   = err_cnt_q;
    bit_cnt   = bit_cnt_q;
  end

endmodule

// File: tb/tb_prbs31_bert_ctrl.sv
// Directed bench for prbs31_bert_ctrl driving a reference PRBS31 stream.
module tb_prbs31_bert_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, rx_bit, rx_valid;
  logic [23:0] win_len;
  logic        busy, locked, done, sync_lost;
  logic [15:0] err_cnt;
  logic [23:0] bit_cnt;

  logic [30:0] gen = 31'h2A5C_1E37;
  logic        last_b;
  int          nvec = 0;
  int          nmis = 0;

  prbs31_bert_ctrl #(
    .SYNC_LEN (32),
    .LOS_BLK  (64),
    .LOS_THR  (8),
    .WIN_W    (24),
    .CNT_W    (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .rx_bit    (rx_bit),
    .rx_valid  (rx_valid),
    .win_len   (win_len),
    .busy      (busy),
    .locked    (locked),
    .done      (done),
    .sync_lost (sync_lost),
    .err_cnt   (err_cnt),
    .bit_cnt   (bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stream: when valid, the next PRBS31 bit, optionally inverted or forced to zero.
  task automatic send(input logic v, input logic corrupt, input logic zero);
    logic b;
    if (v) begin
      b      = gen[30] ^ gen[27];
      gen    = {gen[29:0], b};
      last_b = b;
      rx_bit = zero ? 1'b0 : (b ^ corrupt);
    end else begin
      rx_bit = 1'($urandom);
    end
    rx_valid = v;
    tick();
  endtask

  task automatic send_good(input int n);
    for (int i = 0; i < n; i++) send(1'b1, 1'b0, 1'b0);
  endtask

  task automatic pulse_start(input logic [23:0] wl);
    win_len  = wl;
    start    = 1'b1;
    rx_valid = 1'b0;
    tick();
    start    = 1'b0;
  endtask

  task automatic pulse_abort();
    abort    = 1'b1;
    rx_valid = 1'b0;
    tick();
    abort    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; rx_bit = 1'b0; rx_valid = 1'b0; win_len = '0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    nvec++;
    if ({busy, locked, done, sync_lost} !== 4'b0000) begin
      nmis++; $display("FAIL reset_flags: got %b expected 0000", {busy, locked, done, sync_lost});
    end
    nvec++;
    if (err_cnt !== 16'd0 || bit_cnt !== 24'd0) begin
      nmis++; $display("FAIL reset_counts: got err=%0d bit=%0d expected 0/0", err_cnt, bit_cnt);
    end
  endtask

  task automatic test_lock_window();
    pulse_start(24'd1000);
    nvec++;
    if (busy !== 1'b1 || locked !== 1'b0) begin
      nmis++; $display("FAIL s1_seed: got busy=%b locked=%b expected 1/0", busy, locked);
    end
    send_good(62);
    nvec++;
    if (locked !== 1'b0) begin
      nmis++; $display("FAIL s1_prelock: got locked=%b expected 0 after 62 bits", locked);
    end
    send_good(1);
    nvec++;
    if (locked !== 1'b1 || bit_cnt !== 24'd0) begin
      nmis++; $display("FAIL s1_lock: got locked=%b bit=%0d expected 1/0 after 63 bits", locked, bit_cnt);
    end
    send_good(999);
    nvec++;
    if (done !== 1'b0 || bit_cnt !== 24'd999) begin
      nmis++; $display("FAIL s1_predone: got done=%b bit=%0d expected 0/999", done, bit_cnt);
    end
    send_good(1);
    nvec++;
    if (done !== 1'b1 || busy !== 1'b0 || locked !== 1'b0) begin
      nmis++; $display("FAIL s1_done: got done=%b busy=%b locked=%b expected 1/0/0", done, busy, locked);
    end
    nvec++;
    if (bit_cnt !== 24'd1000 || err_cnt !== 16'd0) begin
      nmis++; $display("FAIL s1_counts: got bit=%0d err=%0d expected 1000/0", bit_cnt, err_cnt);
    end
  endtask

  task automatic test_errors();
    pulse_start(24'd1000);
    send_good(63);
    for (int i = 0; i < 1000; i++) begin
      send(1'b1, ((i % 100) == 0) && (i >= 100) && (i <= 500), 1'b0);
    end
    nvec++;
    if (done !== 1'b1 || bit_cnt !== 24'd1000) begin
      nmis++; $display("FAIL s2_done: got done=%b bit=%0d expected 1/1000", done, bit_cnt);
    end
    nvec++;
    if (err_cnt !== 16'd5 || sync_lost !== 1'b0) begin
      nmis++; $display("FAIL s2_errs: got err=%0d sync_lost=%b expected 5/0", err_cnt, sync_lost);
    end
  endtask

  task automatic test_los();
    int  idx, be, errs;
    logic found;
    pulse_start(24'd0);
    send_good(63);
    send_good(100);
    idx = 100; be = 0; errs = 0; found = 1'b0;
    for (int k = 0; k < 128 && !found; k++) begin
      send(1'b1, 1'b0, 1'b1);
      errs += int'(last_b);
      be   += int'(last_b);
      idx++;
      if (be == 8) begin
        found = 1'b1;
        nvec++;
        if (locked !== 1'b0 || busy !== 1'b1 || sync_lost !== 1'b1) begin
          nmis++; $display("FAIL s3_los: got locked=%b busy=%b sync_lost=%b expected 0/1/1", locked, busy, sync_lost);
        end
        nvec++;
        if (bit_cnt !== 24'(idx) || err_cnt !== 16'(errs)) begin
          nmis++; $display("FAIL s3_los_counts: got bit=%0d err=%0d expected %0d/%0d", bit_cnt, err_cnt, idx, errs);
        end
      end else begin
        nvec++;
        if (locked !== 1'b1) begin
          nmis++; $display("FAIL s3_early_los: got locked=%b expected 1 at bit %0d", locked, idx);
        end
        if ((idx % 64) == 0) be = 0;
      end
    end
    if (!found) begin
      nvec++; nmis++; $display("FAIL s3_no_los: got no loss expected loss within budget");
    end
    send_good(62);
    nvec++;
    if (locked !== 1'b0) begin
      nmis++; $display("FAIL s3_prerelock: got locked=%b expected 0", locked);
    end
    send_good(1);
    nvec++;
    if (locked !== 1'b1 || sync_lost !== 1'b1 || bit_cnt !== 24'(idx)) begin
      nmis++; $display("FAIL s3_relock: got locked=%b sync_lost=%b bit=%0d expected 1/1/%0d", locked, sync_lost, bit_cnt, idx);
    end
    pulse_abort();
  endtask

  task automatic test_sync_flip();
    pulse_start(24'd1000);
    send_good(41);
    send(1'b1, 1'b1, 1'b0);
    send_good(62);
    nvec++;
    if (locked !== 1'b0) begin
      nmis++; $display("FAIL s4_prelock: got locked=%b expected 0 62 bits after flip", locked);
    end
    send_good(1);
    nvec++;
    if (locked !== 1'b1 || bit_cnt !== 24'd0) begin
      nmis++; $display("FAIL s4_lock: got locked=%b bit=%0d expected 1/0 63 bits after flip", locked, bit_cnt);
    end
    pulse_abort();
  endtask

  task automatic test_valid_toggle();
    pulse_start(24'd200);
    for (int i = 0; i < 262; i++) begin
      send(1'b1, 1'b0, 1'b0);
      send(1'b0, 1'b0, 1'b0);
    end
    nvec++;
    if (done !== 1'b0 || bit_cnt !== 24'd199) begin
      nmis++; $display("FAIL s5_predone: got done=%b bit=%0d expected 0/199", done, bit_cnt);
    end
    send(1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b0, 1'b0);
    nvec++;
    if (done !== 1'b1 || bit_cnt !== 24'd200 || err_cnt !== 16'd0) begin
      nmis++; $display("FAIL s5_done: got done=%b bit=%0d err=%0d expected 1/200/0", done, bit_cnt, err_cnt);
    end
  endtask

  task automatic test_abort_start();
    pulse_start(24'd1000);
    send_good(63);
    send_good(40);
    start = 1'b1;
    send(1'b1, 1'b0, 1'b0);
    start = 1'b0;
    nvec++;
    if (locked !== 1'b1 || bit_cnt !== 24'd41) begin
      nmis++; $display("FAIL s6_start_busy: got locked=%b bit=%0d expected 1/41", locked, bit_cnt);
    end
    send_good(9);
    abort = 1'b1;
    send(1'b1, 1'b0, 1'b0);
    abort = 1'b0;
    nvec++;
    if (busy !== 1'b0 || locked !== 1'b0 || done !== 1'b0 || bit_cnt !== 24'd50) begin
      nmis++; $display("FAIL s6_abort: got busy=%b locked=%b done=%b bit=%0d expected 0/0/0/50", busy, locked, done, bit_cnt);
    end
    pulse_start(24'd1000);
    send_good(36);
    nvec++;
    if (busy !== 1'b1 || locked !== 1'b0) begin
      nmis++; $display("FAIL s6_in_sync: got busy=%b locked=%b expected 1/0", busy, locked);
    end
    rst_n = 1'b1;
    send(1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    nvec++;
    if ({busy, locked, done, sync_lost} !== 4'b0000 || err_cnt !== 16'd0 || bit_cnt !== 24'd0) begin
      nmis++; $display("FAIL s6_reset: got flags=%b err=%0d bit=%0d expected 0000/0/0", {busy, locked, done, sync_lost}, err_cnt, bit_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_lock_window();
    test_errors();
    test_los();
    test_sync_flip();
    test_valid_toggle();
    test_abort_start();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
